// File: rtl/bram_load_responder_pkg.sv
// Shared handshake definitions for the BRAM load responder and its response buffer.
// Holds the BRAM read latency and the pointer sizing helper.
package bram_load_responder_pkg;

   // Cycles between ram_en and valid ram_dout.
   localparam int RAM_RD_LATENCY = 1;

   // Width of a pointer that wraps modulo depth; at least 1 bit so DEPTH=1 stays legal.
   function automatic int ptrBits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/bram_load_responder_resp_fifo.sv
// Response buffer: circular FIFO with combinational head read and pointers wrapping modulo DEPTH.
// A push while full is only accepted together with a pop, so the buffer can never overflow.
module resp_fifo
   import bram_load_responder_pkg::*;
#(
   parameter int DATA_TYPE = 32,
   parameter int DEPTH     = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [DATA_TYPE-1:0]       pushData,
   input  logic                       pop,
   output logic [DATA_TYPE-1:0]       popData,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = ptrBits(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_TYPE-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     wrPtr;
   logic [PTR_W-1:0]     rdPtr;
   logic                 doPush;
   logic                 doPop;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign doPop   = pop && !empty;
   assign doPush  = push && (!full || doPop);
   assign popData = mem[rdPtr];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= nextPtr(wrPtr);
         if (doPop)  rdPtr <= nextPtr(rdPtr);
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; the cleared count and pointers make stale words unreachable.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/bram_load_responder.sv
// Load-port responder for a 1-cycle BRAM: forwards accepted addresses straight to the BRAM,
// captures the read word one cycle later and returns words in issue order through a small FIFO.
module bram_load_responder
   import bram_load_responder_pkg::*;
#(
   parameter int DATA_TYPE = 32,
   parameter int ADDR_TYPE = 32,
   parameter int DEPTH     = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_TYPE-1:0] addrIn,
   input  logic                 addrIn_valid,
   output logic                 addrIn_ready,
   output logic [DATA_TYPE-1:0] dataOut,
   output logic                 dataOut_valid,
   input  logic                 dataOut_ready,
   output logic                 ram_en,
   output logic [ADDR_TYPE-1:0] ram_addr,
   input  logic [DATA_TYPE-1:0] ram_dout
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int OCC_W = $clog2(DEPTH + RAM_RD_LATENCY + 1);

   logic             inflight;
   logic             addrXfer;
   logic             dataXfer;
   logic             fifoFull;
   logic             fifoEmpty;
   logic [CNT_W-1:0] fifoCount;
   logic [OCC_W-1:0] occupancy;

   assign addrXfer = addrIn_valid && addrIn_ready;
   assign ram_en   = addrXfer;
   assign ram_addr = addrIn;

   assign dataOut_valid = !fifoEmpty;
   assign dataXfer      = dataOut_valid && dataOut_ready;

   // Set by each accepted address; marks the cycle in which ram_dout carries its word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) inflight <= 1'b0;
      else      inflight <= addrXfer;
   end

   // Ready reserves a FIFO slot for the word still inside the BRAM, so it never depends on
   // dataOut_ready or addrIn_valid and a push can never find the buffer full.
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      occupancy    = OCC_W'(fifoCount) + OCC_W'(inflight);
      addrIn_ready = rst && !fifoFull && (occupancy < OCC_W'(DEPTH));
   end

   resp_fifo #(
      .DATA_TYPE (DATA_TYPE),
      .DEPTH     (DEPTH)
   ) u_respFifo (
      .clk      (clk),
      .rst      (rst),
      .push     (inflight),
      .pushData (ram_dout),
      .pop      (dataXfer),
      .popData  (dataOut),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCount)
   );

endmodule

// File: doc/bram_load_responder.md
BRAM_LOAD_RESPONDER -- requirements
Module: bram_load_responder

Interface
REQ-001 SHALL have parameter DATA_TYPE, default 32, width of read data.
REQ-002 SHALL have parameter ADDR_TYPE, default 32, width of load address.
REQ-003 SHALL have parameter DEPTH, default 3, response-buffer capacity in words; legal range 1..16.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port addrIn  input  ADDR_TYPE  load address from a load port's address channel.
REQ-007 SHALL have port addrIn_valid  input  1; addrIn_ready  output  1  (address handshake).
REQ-008 SHALL have port dataOut  output  DATA_TYPE  read data to the load port's data-from-memory channel.
REQ-009 SHALL have port dataOut_valid  output  1; dataOut_ready  input  1  (data handshake).
REQ-010 SHALL have port ram_en  output  1  BRAM read enable.
REQ-011 SHALL have port ram_addr  output  ADDR_TYPE  BRAM read address.
REQ-012 SHALL have port ram_dout  input  DATA_TYPE  BRAM read data, valid exactly 1 cycle after ram_en.

Function
- Address transfer: addrIn_valid and addrIn_ready both high at a rising edge.
- Data transfer: dataOut_valid and dataOut_ready both high at a rising edge.
REQ-013 SHALL drive ram_en = addrIn_valid AND addrIn_ready, and ram_addr = addrIn, combinationally.
REQ-014 SHALL set a 1-bit inflight flag on every address transfer and clear it on the next edge unless another transfer occurs.
REQ-015 SHALL write ram_dout into the response FIFO at the edge ending the cycle in which inflight is high.
REQ-016 SHALL present the FIFO head on dataOut, with dataOut_valid = FIFO not empty.
REQ-017 SHALL pop the FIFO on each data transfer.
REQ-018 SHALL compute occupancy = fifo_count + inflight, and drive addrIn_ready = (occupancy < DEPTH).
REQ-019 SHALL NOT let addrIn_ready depend combinationally on dataOut_ready or addrIn_valid.
REQ-020 SHALL give a minimum latency of 2 cycles: address accepted at edge T yields dataOut_valid after edge T+2.
REQ-021 SHALL sustain one transfer per cycle when DEPTH >= 3 and dataOut_ready is held high.
REQ-022 SHALL return responses in exactly the order the addresses were accepted.
REQ-023 SHALL handle push and pop at the same edge with no net count change.
REQ-024 SHALL never overflow the FIFO, because of REQ-018.
REQ-025 SHALL hold dataOut stable while dataOut_valid is high and dataOut_ready is low.
REQ-026 SHALL size fifo_count to clog2(DEPTH+1) bits and wrap the read/write pointers modulo DEPTH.

Reset
REQ-027 SHALL, while rst is low, hold fifo_count=0, pointers=0, inflight=0, dataOut_valid=0, addrIn_ready=0, ram_en=0.
REQ-028 SHALL discard any in-flight BRAM data when reset is asserted mid-operation; no stale word appears after release.
REQ-029 SHALL raise addrIn_ready in the first cycle after rst deasserts.

Structure
REQ-030 SHALL place the BRAM read latency constant (RAM_RD_LATENCY = 1) in the shared handshake package.
REQ-031 SHALL implement the response buffer as one sub-module, resp_fifo (parameters DATA_TYPE, DEPTH; push/pop/full/empty/count).
REQ-032 SHALL keep the inflight flag and the occupancy/ready logic in the top module.

Verification
REQ-033 Single read: RAM[0x10]=0xCAFE; addrIn=0x10 accepted at edge 0 -> ram_en high in cycle 0; dataOut=0xCAFE valid after edge 2.
REQ-034 Streaming: addresses 0..7 back-to-back with dataOut_ready=1 -> 8 responses in order on 8 consecutive cycles; addrIn_ready never drops (DEPTH=3).
REQ-035 Backpressure: dataOut_ready=0 while 5 addresses are offered -> exactly 3 accepted, then addrIn_ready=0 and dataOut held at the first word; raise ready -> remaining 2 accepted and all 5 returned in order.
REQ-036 Simultaneous push/pop: FIFO count=1, issue an address while popping -> count stays 1; no loss or duplication.
REQ-037 Reset mid-flight: assert rst one cycle after an address transfer -> after release dataOut_valid=0, no response ever emerges, addrIn_ready=1.
REQ-038 Random: random valid/ready over 10k cycles against a scoreboard -> data equals RAM contents in issue order, and occupancy never exceeds DEPTH.
